// File: rtl/pixel_fb_writer_pkg.sv
// Purpose : shared screen geometry, colour constants and state encoding for the pixel writer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pixel_fb_writer_pkg;

  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int FB_WORDS    = SCREEN_W * SCREEN_H;  // 76800
  localparam int FB_ADDR_W   = 17;
  localparam int FB_COLOUR_W = 3;
  localparam int X_W         = 9;
  localparam int Y_W         = 8;

  localparam logic [FB_COLOUR_W-1:0] COLOUR_WHITE = 3'b111;
  localparam logic [FB_COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } fbState_t;

endpackage

// File: rtl/pixel_fb_writer_fifo.sv
// Purpose : small synchronous FIFO holding packed pixel writes; head word is visible combinationally.
// Latency : a word written at edge k is readable (empty low) after edge k.
// Backpressure: writes ignored when full, reads ignored when empty.
// Ports   : clock/reset; wrEn/wrData push; rdEn pop; rdData head word; full/empty flags.
module pixel_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PTR_W:0]    wrPtr;
  logic [PTR_W:0]    rdPtr;
  logic              doWrite;
  logic              doRead;

  assign doWrite = wrEn && !full;
  assign doRead  = rdEn && !empty;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                  (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign rdData = mem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (doWrite) mem[wrPtr[PTR_W-1:0]] <= wrData;
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Purpose : accepts (x,y,colour) pixel writes, clips off-screen ones, drives the framebuffer write port; hardware screen clear.
// Latency : pixel accepted at edge k into an empty FIFO appears on fb_* in the cycle after edge k+1; 1 pixel/clock sustained.
// Backpressure: pix_ready low when FIFO full, a clear is pending, or the clear sweep is running.
// Ports   : clock, reset (sync, active-high); pix_valid/pix_ready/pix_x/pix_y/pix_colour handshake;
//           clear_req/clear_colour clear request; busy; fb_addr/fb_data/fb_wren RAM write port; clip_count.
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
#(
  parameter int WIDTH      = SCREEN_W,
  parameter int HEIGHT     = SCREEN_H,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int COLOUR_W   = FB_COLOUR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [X_W-1:0]      pix_x,
  input  logic [Y_W-1:0]      pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                busy,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [COLOUR_W-1:0] fb_data,
  output logic                fb_wren,
  output logic [7:0]          clip_count
);

  localparam int                FIFO_W    = X_W + Y_W + COLOUR_W;
  localparam logic [X_W-1:0]    X_LIMIT   = X_W'(WIDTH);
  localparam logic [Y_W-1:0]    Y_LIMIT   = Y_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  fbState_t            state;
  fbState_t            stateNext;
  logic                clearPending;
  logic [COLOUR_W-1:0] clearColourQ;
  logic [ADDR_W-1:0]   clearAddr;

  logic                fifoFull;
  logic                fifoEmpty;
  logic [FIFO_W-1:0]   headDat;
  logic [X_W-1:0]      headX;
  logic [Y_W-1:0]      headY;
  logic [COLOUR_W-1:0] headColour;
  logic [ADDR_W-1:0]   headYExt;
  logic [ADDR_W-1:0]   headAddr;

  logic                accept;
  logic                clipped;
  logic                push;
  logic                pop;

  // Ready is held low while reset is asserted, not just after the first reset edge.
  assign pix_ready = !reset && !fifoFull && (state == RUN) && !clearPending;
  assign accept    = pix_valid && pix_ready;
  assign clipped   = (pix_x >= X_LIMIT) || (pix_y >= Y_LIMIT);
  assign push      = accept && !clipped;
  assign pop       = (state == RUN) && !fifoEmpty;

  pixel_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (push),
    .wrData ({pix_x, pix_y, pix_colour}),
    .rdEn   (pop),
    .rdData (headDat),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign {headX, headY, headColour} = headDat;

  // y*320 + x as two shifts and adds; widened to ADDR_W first so nothing is truncated.
  assign headYExt = ADDR_W'(headY);
  assign headAddr = (headYExt << 8) + (headYExt << 6) + ADDR_W'(headX);

  assign busy = (state == CLEAR) || clearPending || !fifoEmpty || fb_wren;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      // The clear waits for every pixel queued ahead of it to drain.
      RUN:     if (clearPending && fifoEmpty) stateNext = CLEAR;
      CLEAR:   if (clearAddr == LAST_ADDR)    stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clearPending <= 1'b0;
      clearColourQ <= '0;
      clearAddr    <= '0;
      fb_wren      <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      clip_count   <= '0;
    end else begin
      fb_wren <= 1'b0;

      if (accept && clipped && (clip_count != 8'hFF)) clip_count <= clip_count + 8'd1;

      // A request while pending or sweeping is dropped, not queued.
      if ((state == RUN) && !clearPending && clear_req) begin
        clearPending <= 1'b1;
        clearColourQ <= clear_colour;
      end

      if (state == RUN) begin
        clearAddr <= '0;
        if (pop) begin
          fb_wren <= 1'b1;
          fb_addr <= headAddr;
          fb_data <= headColour;
        end
      end else begin
        fb_wren   <= 1'b1;
        fb_addr   <= clearAddr;
        fb_data   <= clearColourQ;
        clearAddr <= clearAddr + 1'b1;
        if (clearAddr == LAST_ADDR) clearPending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Purpose : self-checking bench for pixel_fb_writer; ordered write scoreboard plus directed literal checks.
// Latency : n/a.
// Backpressure: stimulus honours pix_ready.
module tb_pixel_fb_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [8:0] pix_x = '0;
  logic [7:0] pix_y = '0;
  logic [2:0] pix_colour = '0;
  logic       clear_req = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       busy;
  logic [16:0] fb_addr;
  logic [2:0] fb_data;
  logic       fb_wren;
  logic [7:0] clip_count;

  pixel_fb_writer dut (
    .clock        (clock),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_colour   (pix_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_wren      (fb_wren),
    .clip_count   (clip_count)
  );

  always #5 clock = ~clock;

  // Expected framebuffer write stream: single pixels, or a whole-screen sweep marker.
  typedef struct {
    bit isClear;
    int addr;
    int data;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErrors = 0;
  int   mClip = 0;
  bit   mClearOut = 0;
  int   clearIdx = 0;
  int   clearWrites = 0;
  int   readyLeak = 0;
  bit   chkEn = 0;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model and compare process: at each falling edge, check outputs produced by the
  // previous rising edge, then record what the next rising edge will transfer.
  always @(negedge clock) begin
    if (chkEn) begin
      chk("clip_count", int'(clip_count), mClip);
      if (fb_wren) begin
        if (expQ.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else if (expQ[0].isClear) begin
          chk("clear_addr", int'(fb_addr), clearIdx);
          chk("clear_data", int'(fb_data), expQ[0].data);
          if (pix_ready && clearIdx != 76799) readyLeak++;
          clearIdx++;
          clearWrites++;
          if (clearIdx == 76800) begin
            void'(expQ.pop_front());
            clearIdx  = 0;
            mClearOut = 0;
          end
        end else begin
          chk("pix_addr", int'(fb_addr), expQ[0].addr);
          chk("pix_data", int'(fb_data), expQ[0].data);
          void'(expQ.pop_front());
        end
      end
      if (reset) begin
        expQ.delete();
        mClip     = 0;
        clearIdx  = 0;
        mClearOut = 0;
      end else begin
        if (pix_valid && pix_ready) begin
          if (int'(pix_x) >= 320 || int'(pix_y) >= 240) begin
            if (mClip < 255) mClip++;
          end else begin
            expQ.push_back('{1'b0, int'(pix_y) * 320 + int'(pix_x), int'(pix_colour)});
          end
        end
        if (clear_req && !mClearOut) begin
          expQ.push_back('{1'b1, 0, int'(clear_colour)});
          mClearOut = 1;
        end
      end
    end
  end

  task automatic sendPixel(input int x, input int y, input int c);
    bit got;
    got = 0;
    pix_x = 9'(x);
    pix_y = 8'(y);
    pix_colour = 3'(c);
    pix_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      got = pix_ready;
      tick();
    end
    pix_valid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic waitWren(input string name);
    int n;
    n = 0;
    while (!fb_wren && n < 50) begin
      tick();
      n++;
    end
    chk(name, int'(fb_wren), 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", nErrors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, wr, first, last, n, prevA;
    bit got, prevW;

    // ---- reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("ready_in_reset", int'(pix_ready), 0);
    chkEn = 1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_ready", int'(pix_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wren", int'(fb_wren), 0);
    chk("rst_addr", int'(fb_addr), 0);
    chk("rst_data", int'(fb_data), 0);
    chk("rst_clip", int'(clip_count), 0);

    // ---- 1: single pixel latency
    sendPixel(0, 0, 3'b100);
    chk("t1_wren_edge_k", int'(fb_wren), 0);
    tick();
    chk("t1_wren_edge_k1", int'(fb_wren), 1);
    chk("t1_addr", int'(fb_addr), 0);
    chk("t1_data", int'(fb_data), 4);
    tick();
    chk("t1_wren_pulse_end", int'(fb_wren), 0);
    chk("t1_busy_idle", int'(busy), 0);

    // ---- 2: far corner, clipping, saturation
    sendPixel(319, 239, 3'b010);
    waitWren("t2_corner_seen");
    chk("t2_corner_addr", int'(fb_addr), 76799);
    chk("t2_corner_data", int'(fb_data), 2);
    sendPixel(320, 10, 1);
    sendPixel(5, 240, 1);
    chk("t2_clip_two", int'(clip_count), 2);
    for (int i = 0; i < 298; i++) sendPixel(320 + (i % 150), 5, 1);
    tick();
    chk("t2_clip_sat", int'(clip_count), 255);

    // ---- 3: eight-pixel burst with valid held
    acc = 0; cyc = 0; wr = 0; first = -1; last = -1;
    pix_x = 9'd0; pix_y = 8'd3; pix_colour = 3'd0;
    pix_valid = 1'b1;
    while ((acc < 8 || cyc < 14) && cyc < 40) begin
      got = pix_ready && pix_valid;
      tick();
      cyc++;
      if (fb_wren) begin
        wr++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (got) begin
        acc++;
        if (acc == 8) begin
          pix_valid = 1'b0;
          chk("t3_accept_cycles", cyc, 8);
        end else begin
          pix_x = 9'(acc * 37);
          pix_y = 8'(acc * 29 + 3);
          pix_colour = 3'(acc);
        end
      end
    end
    pix_valid = 1'b0;
    chk("t3_accepted", acc, 8);
    chk("t3_writes", wr, 8);
    chk("t3_contiguous_span", last - first + 1, 8);

    // ---- 4/6: queued pixels then clear; repeated requests ignored
    sendPixel(1, 2, 1);
    sendPixel(2, 3, 2);
    pix_x = 9'd3; pix_y = 8'd4; pix_colour = 3'd3;
    pix_valid = 1'b1;
    clear_req = 1'b1;
    clear_colour = 3'b111;
    chk("t4_ready_with_req", int'(pix_ready), 1);
    tick();
    pix_valid = 1'b0;
    clear_req = 1'b0;
    chk("t4_ready_after_req", int'(pix_ready), 0);
    tick();
    tick();
    clear_req = 1'b1;
    clear_colour = 3'b000;
    tick();
    clear_req = 1'b0;
    clearWrites = 0;
    readyLeak = 0;
    n = 0; prevA = -1; prevW = 0;
    while (busy && n < 80000) begin
      prevW = fb_wren;
      prevA = int'(fb_addr);
      if (n == 600) begin
        clear_req = 1'b1;
        clear_colour = 3'b010;
      end
      if (n == 601) clear_req = 1'b0;
      tick();
      n++;
    end
    clear_req = 1'b0;
    chk("t4_busy_fell", int'(busy), 0);
    chk("t4_clear_writes", clearWrites, 76800);
    chk("t4_last_wren", int'(prevW), 1);
    chk("t4_last_addr", prevA, 76799);
    chk("t4_ready_low_in_clear", readyLeak, 0);
    chk("t4_ready_after", int'(pix_ready), 1);

    // ---- 5: reset in the middle of a clear
    clear_req = 1'b1;
    clear_colour = 3'b101;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (!(fb_wren && fb_addr == 17'd1000) && n < 3000) begin
      tick();
      n++;
    end
    chk("t5_reached_1000", int'(fb_wren && fb_addr == 17'd1000), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_ready_in_reset", int'(pix_ready), 0);
    @(posedge clock);
    #1;
    chk("t5_wren_after_reset", int'(fb_wren), 0);
    chk("t5_busy_after_reset", int'(busy), 0);
    reset = 1'b0;
    #1;
    chk("t5_ready_after_reset", int'(pix_ready), 1);
    chk("t5_clip_after_reset", int'(clip_count), 0);
    sendPixel(10, 1, 6);
    waitWren("t5_pixel_seen");
    chk("t5_addr", int'(fb_addr), 330);
    chk("t5_data", int'(fb_data), 6);
    repeat (3) tick();
    chk("final_queue_empty", expQ.size(), 0);
    chk("final_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
